// File: rtl/alu_ctrl_decode_pkg.sv
// Shared types and constants for the ID stage: ALU op codes, operand selects,
// RV32I opcodes and the registered decode bundle. Honours ILLEGAL_INSN_EN.
package alu_ctrl_decode_pkg;

    localparam int unsigned WORD_SIZE  = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_LUI   = 4'd10,
        ALU_AUIPC = 4'd11
    } alu_op_e;

    localparam logic OP1_SEL_RS1 = 1'b0;
    localparam logic OP1_SEL_PC  = 1'b1;
    localparam logic OP2_SEL_RS2 = 1'b0;
    localparam logic OP2_SEL_IMM = 1'b1;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [3:0]            alu_op;
        logic                  op1_sel;
        logic                  op2_sel;
        logic [WORD_SIZE-1:0]  imm;
        logic [WORD_SIZE-1:0]  pc;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
`ifdef ILLEGAL_INSN_EN
        logic                  illegal;
`endif
    } id_bundle_t;

    // Shared OP / OP-IMM map; alt selects SUB/SRA where funct7[5] applies.
    function automatic alu_op_e alu_from_funct(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        unique case (funct3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode_skid.sv
// id_skid_buffer: generic 2-entry valid/ready register (output entry plus one skid entry)
// with flush; o_Ready is registered so upstream never sees a combinational path.
module id_skid_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Flush,
    input  logic             i_Valid,
    output logic             o_Ready,
    input  logic [WIDTH-1:0] i_Data,
    output logic             o_Valid,
    input  logic             i_Ready,
    output logic [WIDTH-1:0] o_Data
);

    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             accept;

    assign accept = i_Valid & ready_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        out_data_d   = out_data_q;
        skid_data_d  = skid_data_q;
        if (i_Flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // Skid full implies output full and ready_q low, so no accept here.
            if (i_Ready) begin
                out_data_d   = skid_data_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q || i_Ready) begin
                out_data_d  = i_Data;
                out_valid_d = 1'b1;
            end else begin
                skid_data_d  = i_Data;
                skid_valid_d = 1'b1;
            end
        end else if (i_Ready) begin
            out_valid_d = 1'b0;
        end
        ready_d = !skid_valid_d;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            out_data_q   <= '0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
            out_data_q   <= out_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign o_Ready = ready_q;
    assign o_Valid = out_valid_q;
    assign o_Data  = out_data_q;

endmodule

// File: rtl/alu_ctrl_decode.sv
// RV32I decode stage: instruction word -> ALU op, operand selects, immediate and register
// indices, registered through a 2-entry skid buffer. ILLEGAL_INSN_EN adds o_Illegal.
module alu_ctrl_decode
    import alu_ctrl_decode_pkg::*;
(
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_Flush,
    input  logic                  i_Valid,
    output logic                  o_Ready,
    input  logic [WORD_SIZE-1:0]  i_Instr,
    input  logic [WORD_SIZE-1:0]  i_Pc,
    output logic                  o_Valid,
    input  logic                  i_Ready,
    output logic [3:0]            o_AluOp,
    output logic                  o_Op1Sel,
    output logic                  o_Op2Sel,
    output logic [WORD_SIZE-1:0]  o_Imm,
    output logic [WORD_SIZE-1:0]  o_Pc,
    output logic [REG_ADDR_W-1:0] o_Rs1,
    output logic [REG_ADDR_W-1:0] o_Rs2,
    output logic [REG_ADDR_W-1:0] o_Rd,
`ifdef ILLEGAL_INSN_EN
    output logic                  o_Illegal,
`endif
    output logic                  o_RegWrite
);

    id_bundle_t           dec, held;
    logic                 illegal;
    logic [6:0]           opcode, funct7;
    logic [2:0]           funct3;
    logic [WORD_SIZE-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;

    assign opcode = i_Instr[6:0];
    assign funct3 = i_Instr[14:12];
    assign funct7 = i_Instr[31:25];

    assign imm_i = {{20{i_Instr[31]}}, i_Instr[31:20]};
    assign imm_s = {{20{i_Instr[31]}}, i_Instr[31:25], i_Instr[11:7]};
    assign imm_b = {{19{i_Instr[31]}}, i_Instr[31], i_Instr[7], i_Instr[30:25],
                    i_Instr[11:8], 1'b0};
    assign imm_j = {{11{i_Instr[31]}}, i_Instr[31], i_Instr[19:12], i_Instr[20],
                    i_Instr[30:21], 1'b0};
    // The ALU applies the <<12 for LUI/AUIPC, so the U immediate stays right-justified.
    assign imm_u = {12'b0, i_Instr[31:12]};

    always_comb begin
        dec         = '0;
        illegal     = 1'b0;
        dec.alu_op  = ALU_ADD;
        dec.op1_sel = OP1_SEL_RS1;
        dec.op2_sel = OP2_SEL_RS2;
        dec.pc      = i_Pc;
        dec.rs1     = i_Instr[19:15];
        dec.rs2     = i_Instr[24:20];
        dec.rd      = i_Instr[11:7];
        case (opcode)
            OPC_OP: begin
                dec.alu_op    = alu_from_funct(funct3, funct7[5]);
                dec.reg_write = 1'b1;
                illegal = !((funct7 == 7'h00) ||
                            (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                dec.alu_op    = alu_from_funct(funct3, funct3 == 3'b101 && funct7[5]);
                dec.op2_sel   = OP2_SEL_IMM;
                dec.imm       = imm_i;
                dec.reg_write = 1'b1;
                illegal = (funct3 == 3'b001 && funct7 != 7'h00) ||
                          (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20);
            end
            OPC_LUI: begin
                dec.alu_op    = ALU_LUI;
                dec.op2_sel   = OP2_SEL_IMM;
                dec.imm       = imm_u;
                dec.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec.alu_op    = ALU_AUIPC;
                dec.op1_sel   = OP1_SEL_PC;
                dec.op2_sel   = OP2_SEL_IMM;
                dec.imm       = imm_u;
                dec.reg_write = 1'b1;
            end
            OPC_LOAD: begin
                dec.op2_sel   = OP2_SEL_IMM;
                dec.imm       = imm_i;
                dec.reg_write = 1'b1;
            end
            OPC_STORE: begin
                dec.op2_sel = OP2_SEL_IMM;
                dec.imm     = imm_s;
            end
            OPC_JAL: begin
                dec.op1_sel   = OP1_SEL_PC;
                dec.op2_sel   = OP2_SEL_IMM;
                dec.imm       = imm_j;
                dec.reg_write = 1'b1;
            end
            OPC_JALR: begin
                dec.op2_sel   = OP2_SEL_IMM;
                dec.imm       = imm_i;
                dec.reg_write = 1'b1;
            end
            OPC_BRANCH: begin
                dec.imm = imm_b;
                case (funct3[2:1])
                    2'b00:   dec.alu_op = ALU_SUB;
                    2'b10:   dec.alu_op = ALU_SLT;
                    2'b11:   dec.alu_op = ALU_SLTU;
                    default: illegal    = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            dec.alu_op    = ALU_ADD;
            dec.reg_write = 1'b0;
        end
        if (dec.rd == '0) begin
            dec.reg_write = 1'b0;
        end
`ifdef ILLEGAL_INSN_EN
        dec.illegal = illegal;
`endif
    end

    id_skid_buffer #(
        .WIDTH($bits(id_bundle_t))
    ) u_skid (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Flush (i_Flush),
        .i_Valid (i_Valid),
        .o_Ready (o_Ready),
        .i_Data  (dec),
        .o_Valid (o_Valid),
        .i_Ready (i_Ready),
        .o_Data  (held)
    );

    assign o_AluOp    = held.alu_op;
    assign o_Op1Sel   = held.op1_sel;
    assign o_Op2Sel   = held.op2_sel;
    assign o_Imm      = held.imm;
    assign o_Pc       = held.pc;
    assign o_Rs1      = held.rs1;
    assign o_Rs2      = held.rs2;
    assign o_Rd       = held.rd;
    assign o_RegWrite = held.reg_write;
`ifdef ILLEGAL_INSN_EN
    assign o_Illegal  = held.illegal;
`endif

endmodule

// File: tb/tb_alu_ctrl_decode.sv
// Directed self-checking bench for alu_ctrl_decode: decode vectors, back-pressure,
// flush and reset-mid-stall. Builds with or without ILLEGAL_INSN_EN.
module tb_alu_ctrl_decode;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] instr, pc;
    logic        in_ready, out_valid, op1_sel, op2_sel, reg_write;
    logic [3:0]  alu_op;
    logic [31:0] imm, out_pc;
    logic [4:0]  rs1, rs2, rd;
`ifdef ILLEGAL_INSN_EN
    logic        illegal;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_ctrl_decode dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Flush    (flush),
        .i_Valid    (in_valid),
        .o_Ready    (in_ready),
        .i_Instr    (instr),
        .i_Pc       (pc),
        .o_Valid    (out_valid),
        .i_Ready    (out_ready),
        .o_AluOp    (alu_op),
        .o_Op1Sel   (op1_sel),
        .o_Op2Sel   (op2_sel),
        .o_Imm      (imm),
        .o_Pc       (out_pc),
        .o_Rs1      (rs1),
        .o_Rs2      (rs2),
        .o_Rd       (rd),
`ifdef ILLEGAL_INSN_EN
        .o_Illegal  (illegal),
`endif
        .o_RegWrite (reg_write)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] i, input logic [31:0] p);
        in_valid = 1'b1;
        instr    = i;
        pc       = p;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; pc = '0;
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_aluop", 32'(alu_op), 32'd0);
        chk("rst_imm", imm, 32'd0);

        // Streaming decode with the consumer always ready.
        out_ready = 1'b1;
        send(32'h002081B3, 32'h100); step();
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_op", 32'(alu_op), 32'd0);
        chk("add_sel", {30'd0, op1_sel, op2_sel}, 32'd0);
        chk("add_regs", {17'd0, rs1, rs2, rd}, {17'd0, 5'd1, 5'd2, 5'd3});
        chk("add_we", 32'(reg_write), 32'd1);
        chk("add_pc", out_pc, 32'h100);
        send(32'h402081B3, 32'h104); step();
        chk("sub_op", 32'(alu_op), 32'd1);
        chk("stream_ready", 32'(in_ready), 32'd1);
        send(32'h40335293, 32'h108); step();
        chk("srai_op", 32'(alu_op), 32'd7);
        chk("srai_op2", 32'(op2_sel), 32'd1);
        chk("srai_shamt", 32'(imm[4:0]), 32'd3);
        chk("srai_regs", {22'd0, rs1, rd}, {22'd0, 5'd6, 5'd5});
        send(32'h00308093, 32'h10C); step();
        chk("addi_op", 32'(alu_op), 32'd0);
        chk("addi_imm", imm, 32'd3);
        send(32'h123450B7, 32'h110); step();
        chk("lui_op", 32'(alu_op), 32'd10);
        chk("lui_imm", imm, 32'h00012345);
        chk("lui_op1", 32'(op1_sel), 32'd0);
        send(32'h12345097, 32'h114); step();
        chk("auipc_op", 32'(alu_op), 32'd11);
        chk("auipc_op1", 32'(op1_sel), 32'd1);
        chk("auipc_imm", imm, 32'h00012345);
        send(32'hFE208EE3, 32'h118); step();
        chk("beq_op", 32'(alu_op), 32'd1);
        chk("beq_imm", imm, 32'hFFFFFFFC);
        chk("beq_we", 32'(reg_write), 32'd0);
        chk("beq_op2", 32'(op2_sel), 32'd0);
        send(32'h00208033, 32'h11C); step();
        chk("rd0_we", 32'(reg_write), 32'd0);
        send(32'h000001FF, 32'h120); step();
        chk("unk_op", 32'(alu_op), 32'd0);
        chk("unk_we", 32'(reg_write), 32'd0);
`ifdef ILLEGAL_INSN_EN
        chk("unk_illegal", 32'(illegal), 32'd1);
`endif
        in_valid = 1'b0; step();
        chk("idle_valid", 32'(out_valid), 32'd0);

        // Back-pressure: three stalled edges, two instructions sent.
        out_ready = 1'b0;
        send(32'h002081B3, 32'h200); step();
        chk("bp_first_valid", 32'(out_valid), 32'd1);
        chk("bp_first_ready", 32'(in_ready), 32'd1);
        send(32'h402081B3, 32'h204); step();
        chk("bp_hold_pc", out_pc, 32'h200);
        chk("bp_skid_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0; step();
        chk("bp_hold2_op", 32'(alu_op), 32'd0);
        chk("bp_hold2_pc", out_pc, 32'h200);
        chk("bp_hold2_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1; step();
        chk("bp_drain_valid", 32'(out_valid), 32'd1);
        chk("bp_drain_pc", out_pc, 32'h204);
        chk("bp_drain_op", 32'(alu_op), 32'd1);
        chk("bp_drain_ready", 32'(in_ready), 32'd1);
        step();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Flush while stalled with the skid entry full.
        out_ready = 1'b0;
        send(32'h002081B3, 32'h300); step();
        send(32'h402081B3, 32'h304); step();
        chk("fl_full_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0; flush = 1'b1; step();
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_ready", 32'(in_ready), 32'd1);
        flush = 1'b0; out_ready = 1'b1;
        send(32'h00308093, 32'h308); step();
        chk("fl_next_valid", 32'(out_valid), 32'd1);
        chk("fl_next_pc", out_pc, 32'h308);
        // Input accepted during a flush is dropped.
        send(32'h402081B3, 32'h30C); flush = 1'b1; step();
        chk("fl_drop_valid", 32'(out_valid), 32'd0);
        flush = 1'b0; in_valid = 1'b0; step();
        chk("fl_after_valid", 32'(out_valid), 32'd0);

        // Reset in the middle of a stall.
        out_ready = 1'b0;
        send(32'h402081B3, 32'h400); step();
        send(32'h402081B3, 32'h404); step();
        in_valid = 1'b0; rst = 1'b1; step();
        rst = 1'b0;
        chk("rs_valid", 32'(out_valid), 32'd0);
        chk("rs_ready", 32'(in_ready), 32'd1);
        chk("rs_aluop", 32'(alu_op), 32'd0);
        out_ready = 1'b1; step();
        chk("rs_no_ghost", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
